// File: rtl/asic_hub_pkg.sv
// asic_hub_pkg: shared types and helpers for the accelerator hub.
//   state_e  - hub FSM states (idle, access in flight, response pending)
//   swap_idx - byte-lane mapping used by the byte-reversal datapath
package asic_hub_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // Full byte reversal: output byte i takes input byte (n_bytes-1-i).
    function automatic int unsigned swap_idx(input int unsigned i, input int unsigned n_bytes);
        return n_bytes - 1 - i;
    endfunction

endpackage

// File: rtl/asic_byteswap.sv
// asic_byteswap: combinational optional full byte reversal.
// Ports:
//   data_in  [DATA_W] - input word
//   en       [1]      - 1 = reverse byte order, 0 = pass through
//   data_out [DATA_W] - resulting word
module asic_byteswap
    import asic_hub_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic              en,
    output logic [DATA_W-1:0] data_out
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] swapped;

    for (genvar i = 0; i < NB; i++) begin : g_byte
        assign swapped[8*i +: 8] = data_in[8*swap_idx(i, NB) +: 8];
    end

    assign data_out = en ? swapped : data_in;

endmodule

// File: rtl/asic_hub.sv
// asic_hub: routes one CPU request at a time to one of N_CHIPS accelerators,
// waits for that chip's ack (or times out) and returns a single response.
// Ports:
//   clk, reset_n                       - clock, async active-low reset
//   req_valid/req_ready                - request handshake
//   req_we, req_endian, req_chip,
//   req_addr, req_wdata                - request payload
//   resp_valid/resp_ready              - response handshake
//   resp_rdata, resp_err               - response payload (rdata already swapped)
//   chip_cs, chip_we, chip_addr,
//   chip_wdata                         - registered accelerator bus
//   chip_rdata, chip_ack               - per-chip read data (flattened) and ack strobes
module asic_hub
    import asic_hub_pkg::*;
#(
    parameter int unsigned N_CHIPS = 4,
    parameter int unsigned BASE_ID = 1,
    parameter int unsigned CHIP_W  = 7,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic                      req_endian,
    input  logic [CHIP_W-1:0]         req_chip,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_rdata,
    output logic                      resp_err,
    output logic [N_CHIPS-1:0]        chip_cs,
    output logic                      chip_we,
    output logic [ADDR_W-1:0]         chip_addr,
    output logic [DATA_W-1:0]         chip_wdata,
    input  logic [N_CHIPS*DATA_W-1:0] chip_rdata,
    input  logic [N_CHIPS-1:0]        chip_ack
);

    localparam int unsigned IDX_W = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e             state;
    logic [IDX_W-1:0]   idx_q;
    logic               endian_q;
    logic [CNT_W-1:0]   cnt;

    logic               hit;
    logic [IDX_W-1:0]   idx;
    logic [N_CHIPS-1:0] sel_onehot;
    logic [DATA_W-1:0]  wdata_sw;
    logic [DATA_W-1:0]  sel_rdata;
    logic [DATA_W-1:0]  rdata_sw;
    logic               ack_sel;

    assign req_ready = (state == StIdle);

    // Address decode: a loop compare avoids a wide subtract whose upper bits go unused.
    always_comb begin
        hit        = 1'b0;
        idx        = '0;
        sel_onehot = '0;
        for (int k = 0; k < int'(N_CHIPS); k++) begin
            if (32'(req_chip) == BASE_ID + 32'(k)) begin
                hit           = 1'b1;
                idx           = IDX_W'(k);
                sel_onehot[k] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < int'(N_CHIPS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_rdata = chip_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // chip_cs is one-hot on the selected chip during ACCESS and zero elsewhere,
    // so masking drops acks from every other chip.
    assign ack_sel = |(chip_ack & chip_cs);

    asic_byteswap #(
        .DATA_W (DATA_W)
    ) u_swap_wr (
        .data_in  (req_wdata),
        .en       (req_endian),
        .data_out (wdata_sw)
    );

    asic_byteswap #(
        .DATA_W (DATA_W)
    ) u_swap_rd (
        .data_in  (sel_rdata),
        .en       (endian_q),
        .data_out (rdata_sw)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= StIdle;
            idx_q      <= '0;
            endian_q   <= 1'b0;
            cnt        <= '0;
            chip_cs    <= '0;
            chip_we    <= 1'b0;
            chip_addr  <= '0;
            chip_wdata <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        if (hit) begin
                            chip_cs    <= sel_onehot;
                            chip_we    <= req_we;
                            chip_addr  <= req_addr;
                            chip_wdata <= wdata_sw;
                            idx_q      <= idx;
                            endian_q   <= req_endian;
                            cnt        <= '0;
                            state      <= StAccess;
                        end else begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            state      <= StResp;
                        end
                    end
                end
                StAccess: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (ack_sel) begin
                        resp_rdata <= chip_we ? '0 : rdata_sw;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        chip_cs    <= '0;
                        state      <= StResp;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        resp_rdata <= '0;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                        chip_cs    <= '0;
                        state      <= StResp;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
